// File: rtl/zvc_decompressor.sv
// zvc_decompressor: expands a zero-value-compressed line back to a dense line, CHUNK positions per cycle
module zvc_decompressor #(
    parameter  int WORD_WIDTH    = 8,
    parameter  int LINE_SIZE     = 128,
    parameter  int DIST_WIDTH    = 7,
    parameter  int MAX_LIFM_RSIZ = 4,
    parameter  int CHUNK         = 16,
    localparam int MT_W          = DIST_WIDTH * MAX_LIFM_RSIZ,
    localparam int PW            = $clog2(LINE_SIZE) + 1
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [LINE_SIZE-1:0]            comp_mask,
    input  logic [LINE_SIZE*WORD_WIDTH-1:0] lifm_comp,
    input  logic [LINE_SIZE*MT_W-1:0]       mt_comp,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [LINE_SIZE*WORD_WIDTH-1:0] lifm_line,
    output logic [LINE_SIZE*MT_W-1:0]       mt_line,
    output logic [PW-1:0]                   nnz
);
    localparam int NCH = LINE_SIZE / CHUNK;
    localparam int CW  = NCH > 1 ? $clog2(NCH) : 1;
    localparam int IW  = PW - 1;

    typedef enum logic [1:0] {IDLE, EXPAND, DONE} state_t;

    state_t                                   state_q, state_d;
    logic [LINE_SIZE-1:0]                     mask_q, mask_d;
    logic [LINE_SIZE-1:0][WORD_WIDTH-1:0]     lifm_in_q, lifm_in_d, lifm_line_q, lifm_line_d;
    logic [LINE_SIZE-1:0][MT_W-1:0]           mt_in_q, mt_in_d, mt_line_q, mt_line_d;
    logic [CW-1:0]                            chunk_q, chunk_d;
    logic [PW-1:0]                            rd_ptr_q, rd_ptr_d, nnz_q, nnz_d, off;
    logic [IW-1:0]                            pos;

    assign in_ready  = state_q == IDLE;
    assign out_valid = state_q == DONE;
    assign lifm_line = lifm_line_q;
    assign mt_line   = mt_line_q;
    assign nnz       = nnz_q;

    // Capture on accept, scatter one chunk of packed slots per EXPAND cycle, hold in DONE until consumed
    always_comb begin
        state_d     = state_q;
        mask_d      = mask_q;
        lifm_in_d   = lifm_in_q;
        mt_in_d     = mt_in_q;
        lifm_line_d = lifm_line_q;
        mt_line_d   = mt_line_q;
        chunk_d     = chunk_q;
        rd_ptr_d    = rd_ptr_q;
        nnz_d       = nnz_q;
        off         = rd_ptr_q;
        pos         = '0;
        case (state_q)
            IDLE: if (in_valid) begin
                mask_d    = comp_mask;
                lifm_in_d = lifm_comp;
                mt_in_d   = mt_comp;
                chunk_d   = '0;
                rd_ptr_d  = '0;
                state_d   = EXPAND;
            end
            EXPAND: begin
                for (int j = 0; j < CHUNK; j++) begin
                    pos              = IW'(int'(chunk_q) * CHUNK + j);
                    lifm_line_d[pos] = mask_q[pos] ? lifm_in_q[off[IW-1:0]] : '0;
                    mt_line_d[pos]   = mask_q[pos] ? mt_in_q[off[IW-1:0]] : '0;
                    off              = off + PW'(mask_q[pos]);
                end
                rd_ptr_d = off;
                chunk_d  = chunk_q + CW'(1);
                if (chunk_q == CW'(NCH - 1)) begin
                    state_d = DONE;
                    nnz_d   = off;
                end
            end
            DONE:    state_d = out_ready ? IDLE : DONE;
            default: state_d = IDLE;
        endcase
    end

    // State register; reset abandons any line in flight and clears all outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            mask_q      <= '0;
            lifm_in_q   <= '0;
            mt_in_q     <= '0;
            lifm_line_q <= '0;
            mt_line_q   <= '0;
            chunk_q     <= '0;
            rd_ptr_q    <= '0;
            nnz_q       <= '0;
        end else begin
            state_q     <= state_d;
            mask_q      <= mask_d;
            lifm_in_q   <= lifm_in_d;
            mt_in_q     <= mt_in_d;
            lifm_line_q <= lifm_line_d;
            mt_line_q   <= mt_line_d;
            chunk_q     <= chunk_d;
            rd_ptr_q    <= rd_ptr_d;
            nnz_q       <= nnz_d;
        end
    end
endmodule

// File: tb/tb_zvc_decompressor.sv
// tb_zvc_decompressor: directed scoreboard bench for the ZVC line expander
module tb_zvc_decompressor;
    localparam int WW = 8, LS = 128, MT = 28, LW = LS * WW, MW = LS * MT, PW = 8;

    logic          clk = 0, reset = 1, in_valid = 0, out_ready = 0;
    logic [LS-1:0] comp_mask = '0;
    logic [LW-1:0] lifm_comp = '0;
    logic [MW-1:0] mt_comp = '0;
    logic          in_ready, out_valid;
    logic [LW-1:0] lifm_line;
    logic [MW-1:0] mt_line;
    logic [PW-1:0] nnz;

    typedef struct {
        logic [LW-1:0] l;
        logic [MW-1:0] m;
        int            n;
    } exp_t;

    exp_t          sb[$];
    int            checks = 0, passed = 0, fails = 0, cyc = 0, n, t1c, t2c, seen;
    logic [LS-1:0] t1k, t2k, mk;
    logic [LW-1:0] t1l, t2l, lv;
    logic [MW-1:0] t1m, t2m, mv;

    zvc_decompressor dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .comp_mask(comp_mask), .lifm_comp(lifm_comp), .mt_comp(mt_comp),
        .out_valid(out_valid), .out_ready(out_ready),
        .lifm_line(lifm_line), .mt_line(mt_line), .nnz(nnz)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic exp_t model(logic [LS-1:0] k, logic [LW-1:0] l, logic [MW-1:0] m);
        exp_t r;
        int   s = 0;
        r.l = '0;
        r.m = '0;
        for (int i = 0; i < LS; i++)
            if (k[i]) begin
                r.l[i*WW +: WW] = l[s*WW +: WW];
                r.m[i*MT +: MT] = m[s*MT +: MT];
                s++;
            end
        r.n = s;
        return r;
    endfunction

    task automatic chk(string tag, int obs, int exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_line(string tag, logic [MW-1:0] obs, logic [MW-1:0] exp, int w);
        int          idx = -1;
        logic [31:0] wm = (32'd1 << w) - 1, ow = 0, ew = 0;
        for (int i = LS - 1; i >= 0; i--)
            if ((32'(obs >> (i * w)) & wm) !== (32'(exp >> (i * w)) & wm)) idx = i;
        if (idx >= 0) begin
            ow = 32'(obs >> (idx * w)) & wm;
            ew = 32'(exp >> (idx * w)) & wm;
        end
        checks++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s first_bad_word=%0d observed=%0h expected=%0h", tag, idx, ow, ew);
        end
    endtask

    task automatic send(logic [LS-1:0] k, logic [LW-1:0] l, logic [MW-1:0] m);
        int w = 0;
        while (!in_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        chk("accept_ready", in_ready, 1);
        comp_mask = k;
        lifm_comp = l;
        mt_comp   = m;
        in_valid  = 1;
        sb.push_back(model(k, l, m));
        @(negedge clk);
        in_valid  = 0;
        comp_mask = ~k;
        lifm_comp = '1;
        mt_comp   = '1;
    endtask

    task automatic wait_valid(output int cnt);
        cnt = 0;
        while (!out_valid && cnt < 40) begin
            @(negedge clk);
            cnt++;
        end
    endtask

    task automatic check_out(string tag);
        exp_t e;
        chk({tag, "_sb_nonempty"}, int'(sb.size() > 0), 1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk({tag, "_valid"}, out_valid, 1);
            chk({tag, "_in_ready"}, in_ready, 0);
            chk_line({tag, "_lifm"}, MW'(lifm_line), MW'(e.l), WW);
            chk_line({tag, "_mt"}, mt_line, e.m, MT);
            chk({tag, "_nnz"}, nnz, e.n);
        end
    endtask

    task automatic consume(string tag);
        out_ready = 1;
        @(negedge clk);
        out_ready = 0;
        chk({tag, "_valid_drop"}, out_valid, 0);
        chk({tag, "_idle_ready"}, in_ready, 1);
    endtask

    initial begin
        t1k = '0; t1k[0] = 1; t1k[8] = 1; t1k[15] = 1;
        t1l = '1; t1l[0 +: WW] = 13; t1l[WW +: WW] = 47; t1l[2*WW +: WW] = 22;
        t1m = '1; t1m[0 +: MT] = 1; t1m[MT +: MT] = 1; t1m[2*MT +: MT] = 1;
        t2k = '0; t2k[5] = 1; t2k[32] = 1; t2k[75] = 1;
        t2l = '1; t2l[0 +: WW] = 15; t2l[WW +: WW] = 74; t2l[2*WW +: WW] = 35;
        t2m = '1; t2m[0 +: MT] = 7; t2m[MT +: MT] = 7; t2m[2*MT +: MT] = 7;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 0;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk_line("rst_lifm", MW'(lifm_line), '0, WW);
        chk_line("rst_mt", mt_line, '0, MT);
        chk("rst_nnz", nnz, 0);

        send(t1k, t1l, t1m);
        wait_valid(n);
        chk("t1_latency", n, 8);
        check_out("t1");
        chk("t1_w0", lifm_line[0 +: WW], 13);
        chk("t1_w8", lifm_line[8*WW +: WW], 47);
        chk("t1_w15", lifm_line[15*WW +: WW], 22);
        chk("t1_mt15", mt_line[15*MT +: MT], 1);
        consume("t1");

        send(t2k, t2l, t2m);
        wait_valid(n);
        chk("t2_latency", n, 8);
        check_out("t2");
        chk("t2_w32", lifm_line[32*WW +: WW], 74);
        chk("t2_w75", lifm_line[75*WW +: WW], 35);
        consume("t2");

        mk = '1;
        for (int k = 0; k < LS; k++) begin
            lv[k*WW +: WW] = WW'(k + 1);
            mv[k*MT +: MT] = MT'(k * 3 + 1);
        end
        send(mk, lv, mv);
        wait_valid(n);
        chk("t3_full_latency", n, 8);
        check_out("t3_full");
        chk("t3_full_nnz", nnz, 128);
        chk("t3_full_w127", lifm_line[127*WW +: WW], 128);
        consume("t3_full");
        send('0, '1, '1);
        wait_valid(n);
        chk("t3_empty_latency", n, 8);
        check_out("t3_empty");
        chk("t3_empty_nnz", nnz, 0);
        chk_line("t3_empty_zero", MW'(lifm_line), '0, WW);
        consume("t3_empty");

        send(t1k, t1l, t1m);
        wait_valid(n);
        check_out("t4");
        for (int i = 0; i < 5; i++) begin
            in_valid  = i[0];
            comp_mask = t2k;
            lifm_comp = t2l;
            mt_comp   = t2m;
            @(negedge clk);
            chk("t4_hold_valid", out_valid, 1);
            chk("t4_hold_in_ready", in_ready, 0);
            chk_line("t4_hold_lifm", MW'(lifm_line), MW'(model(t1k, t1l, t1m).l), WW);
            chk("t4_hold_nnz", nnz, 3);
        end
        in_valid = 0;
        consume("t4");
        seen = 0;
        repeat (12) begin
            @(negedge clk);
            seen += int'(out_valid);
        end
        chk("t4_no_ghost_line", seen, 0);

        send(t1k, t1l, t1m);
        repeat (3) @(negedge clk);
        reset = 1;
        @(negedge clk);
        reset = 0;
        void'(sb.pop_front());
        chk("t5_in_ready", in_ready, 1);
        chk("t5_out_valid", out_valid, 0);
        chk_line("t5_lifm", MW'(lifm_line), '0, WW);
        chk_line("t5_mt", mt_line, '0, MT);
        chk("t5_nnz", nnz, 0);
        seen = 0;
        repeat (10) begin
            @(negedge clk);
            seen += int'(out_valid);
        end
        chk("t5_no_partial", seen, 0);
        send(t1k, t1l, t1m);
        wait_valid(n);
        chk("t5_relatency", n, 8);
        check_out("t5");
        consume("t5");

        comp_mask = t1k;
        lifm_comp = t1l;
        mt_comp   = t1m;
        in_valid  = 1;
        out_ready = 1;
        sb.push_back(model(t1k, t1l, t1m));
        @(negedge clk);
        comp_mask = t2k;
        lifm_comp = t2l;
        mt_comp   = t2m;
        sb.push_back(model(t2k, t2l, t2m));
        wait_valid(n);
        t1c = cyc;
        check_out("t6a");
        @(negedge clk);
        chk("t6_handshake", out_valid, 0);
        wait_valid(n);
        t2c = cyc;
        in_valid = 0;
        check_out("t6b");
        chk("t6_gap", t2c - t1c, 10);
        @(negedge clk);
        out_ready = 0;
        chk("t6_end_valid", out_valid, 0);
        chk("t6_sb_drained", sb.size(), 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
